// File: rtl/hms_display_driver.sv
// hms_display_driver: snapshots binary HH:MM:SS once per frame and scans it onto a 6-digit common-anode 7-segment display
module hms_display_driver #(
  parameter int SCAN_DIV = 25,
  parameter int BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam logic [6:0] SEG_LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [9:0] div_cnt;
  logic [2:0] idx;
  logic [5:0] snap_sec, snap_min;
  logic [4:0] snap_hr;
  logic       wrap, blank;
  logic [5:0] field, tens, units;
  logic [3:0] digit;
  logic [5:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  assign wrap = div_cnt == 10'(SCAN_DIV - 1);
  always_comb begin
    blank = int'(div_cnt) < BLANK;
    field = idx[2] ? {1'b0, snap_hr} : idx[1] ? snap_min : snap_sec;
    tens  = field / 6'd10;
    units = field % 6'd10;
    digit = idx[0] ? tens[3:0] : units[3:0];
    an_d  = blank ? 6'h3F : ~(6'd1 << idx);
    seg_d = blank ? 7'h7F : SEG_LUT[digit];
    dp_d  = blank | snap_sec[0] | ~((idx == 3'd2) | (idx == 3'd4));
  end
  // snapshot lands on the last cycle of a frame so the whole next frame sees one consistent time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      snap_sec <= '0;
      snap_min <= '0;
      snap_hr  <= '0;
      an       <= 6'h3F;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 10'd1;
      if (wrap) idx <= (idx == 3'd5) ? '0 : idx + 3'd1;
      if (wrap && idx == 3'd5) begin
        snap_sec <= sec;
        snap_min <= min;
        snap_hr  <= hr;
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end
endmodule

// File: tb/tb_hms_display_driver.sv
// tb_hms_display_driver: randomized scoreboard bench against a cycle-count reference model, BLANK=1 and BLANK=0 instances
module tb_hms_display_driver;
  localparam int S = 4;
  localparam int F = 6 * S;
  localparam logic [6:0] LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;
  logic       clk = 0;
  logic       rst = 1;
  logic [5:0] sec = 0, min = 0;
  logic [4:0] hr = 0;
  logic [5:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0;
  out_t       q1[$], q0[$];
  int         errors = 0, checks = 0;
  int         t = 0, ss = 0, sm = 0, sh = 0;
  logic [5:0] rs, rm;
  logic [4:0] rh;

  hms_display_driver #(.SCAN_DIV(S), .BLANK(1)) u1 (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .an(an1), .seg(seg1), .dp(dp1));
  hms_display_driver #(.SCAN_DIV(S), .BLANK(0)) u0 (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .an(an0), .seg(seg0), .dp(dp0));

  always #5 clk = ~clk;

  // expected output from cycle number and the time shown this frame
  function automatic out_t model(input int tt, input int bl, input int vs, input int vm, input int vh);
    int pos, d, v, dig;
    out_t o;
    pos = tt % S;
    d = (tt / S) % 6;
    if (pos < bl) return {6'h3F, 7'h7F, 1'b1};
    v = d < 2 ? vs : d < 4 ? vm : vh;
    dig = (d % 2 == 1) ? v / 10 : v % 10;
    o.an = ~(6'b1 << d);
    o.seg = LUT[dig];
    o.dp = !((d == 2 || d == 4) && vs % 2 == 0);
    return o;
  endfunction

  task automatic chk(input string n, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               n, act.an, act.seg, act.dp, exp.an, exp.seg, exp.dp);
    end
  endtask

  task automatic cyc(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    @(negedge clk);
    rst = 0;
    sec = s;
    min = m;
    hr = h;
    q1.push_back(model(t, 1, ss, sm, sh));
    q0.push_back(model(t, 0, ss, sm, sh));
    if (t % F == F - 1) begin
      ss = int'(s);
      sm = int'(m);
      sh = int'(h);
    end
    t++;
  endtask

  task automatic start;
    t = 0;
    ss = 0;
    sm = 0;
    sh = 0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q1.size() > 0) chk("scan_b1", {an1, seg1, dp1}, q1.pop_front());
    if (q0.size() > 0) chk("scan_b0", {an0, seg0, dp0}, q0.pop_front());
  end

  initial begin
    #12;
    chk("reset_b1", {an1, seg1, dp1}, {6'h3F, 7'h7F, 1'b1});
    chk("reset_b0", {an0, seg0, dp0}, {6'h3F, 7'h7F, 1'b1});
    start();
    repeat (2 * F) cyc(6'd56, 6'd34, 5'd12);
    for (int i = 0; i < F; i++) cyc(i < F / 2 ? 6'd56 : 6'd57, 6'd34, 5'd12);
    for (int i = 0; i < F; i++) cyc(6'd57, i < 2 * S + 2 ? 6'd34 : 6'd35, 5'd12);
    repeat (F) cyc(6'd57, 6'd35, 5'd12);
    repeat (2 * F) cyc(6'd60, 6'd35, 5'd31);
    repeat (7) cyc(6'd60, 6'd35, 5'd31);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("async_rst_b1", {an1, seg1, dp1}, {6'h3F, 7'h7F, 1'b1});
    chk("async_rst_b0", {an0, seg0, dp0}, {6'h3F, 7'h7F, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_b1", {an1, seg1, dp1}, {6'h3F, 7'h7F, 1'b1});
    start();
    rs = 0;
    rm = 0;
    rh = 0;
    for (int i = 0; i < 40 * F; i++) begin
      if ($urandom_range(3) == 0) begin
        rs = 6'($urandom_range(63));
        rm = 6'($urandom_range(63));
        rh = 5'($urandom_range(31));
      end
      cyc(rs, rm, rh);
    end
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
